// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: 64 lines x 4 words, 1-cycle hits, word-serial line refill on miss.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module inst_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_icache_ce,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_instq_enable,
    output logic [INST_WIDTH-1:0] icache_instq_inst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [INST_WIDTH-1:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            beat;
    logic [LINES-1:0]      valid_bits;

    logic [TAG_BITS-1:0]   tag_ram  [0:LINES-1];
    logic [INST_WIDTH-1:0] data_ram [0:LINES*4-1];

    logic [INDEX_BITS-1:0] fetch_index;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [1:0]            fetch_offset;
    logic                  fetch_hit;
    logic                  accept_hit;
    logic                  accept_miss;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_offset;
    logic                  refill_beat;
    logic                  last_beat;
    logic                  unused_byte_bits;

    assign fetch_index  = icache_addr[4 +: INDEX_BITS];
    assign fetch_tag    = icache_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign fetch_offset = icache_addr[3:2];
    assign fetch_hit    = valid_bits[fetch_index] && (tag_ram[fetch_index] == fetch_tag);

    assign accept_hit   = (state == IDLE) && pc_icache_ce && fetch_hit;
    assign accept_miss  = (state == IDLE) && pc_icache_ce && !fetch_hit;

    assign req_index    = req_addr[4 +: INDEX_BITS];
    assign req_tag      = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_offset   = req_addr[3:2];
    assign refill_beat  = (state == REFILL) && mem_valid;
    assign last_beat    = refill_beat && (beat == 2'd3);

    // Fetches are word aligned; the byte-lane bits carry no information.
    assign unused_byte_bits = ^{icache_addr[1:0], req_addr[1:0]};

    // Tag and data storage are deliberately left uninitialised; valid_bits gates every use.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            data_ram[{req_index, beat}] <= mem_data;
        end
        if (last_beat) begin
            tag_ram[req_index] <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            req_addr            <= '0;
            beat                <= '0;
            valid_bits          <= '0;
            icache_instq_enable <= 1'b0;
            icache_instq_inst   <= '0;
            mem_req             <= 1'b0;
            mem_addr            <= '0;
        end else begin
            icache_instq_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_icache_ce) begin
                        req_addr <= icache_addr;
                        if (fetch_hit) begin
                            icache_instq_enable <= 1'b1;
                            icache_instq_inst   <= data_ram[{fetch_index, fetch_offset}];
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {icache_addr[ADDR_WIDTH-1:4], 4'b0000};
                            beat     <= 2'd0;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_valid) begin
                        beat <= beat + 2'd1;
                        // Valid is raised only with the final beat so a partial line never hits.
                        if (beat == 2'd3) begin
                            valid_bits[req_index] <= 1'b1;
                            mem_req               <= 1'b0;
                            state                 <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    icache_instq_enable <= 1'b1;
                    icache_instq_inst   <= data_ram[{req_index, req_offset}];
                    state               <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (accept_hit && (stat_hits != 32'hFFFF_FFFF)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (accept_miss && (stat_misses != 32'hFFFF_FFFF)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: the accept strobes only feed the counters.
    logic unused_accept;
    assign unused_accept = accept_hit ^ accept_miss;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: directed fetches push expected words, refill addresses and arrival cycles.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_icache_ce = 1'b0;
    logic [31:0] icache_addr = '0;
    logic        icache_instq_enable;
    logic [31:0] icache_instq_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    inst_cache dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_icache_ce        (pc_icache_ce),
        .icache_addr         (icache_addr),
        .icache_instq_enable (icache_instq_enable),
        .icache_instq_inst   (icache_instq_inst),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_valid           (mem_valid),
        .mem_data            (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits           (stat_hits),
        .stat_misses         (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] maddr_q[$];
    bit          vpat[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a < 32'd16) begin
            case (a[3:2])
                2'd0:    w = 32'h11;
                2'd1:    w = 32'h22;
                2'd2:    w = 32'h33;
                default: w = 32'h44;
            endcase
        end else begin
            w = a ^ 32'hCAFE_0000;
        end
        return w;
    endfunction

    // Backing memory: one beat per cycle unless a gap pattern is queued.
    initial begin
        int  beats;
        bit  v;
        beats = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_valid = 1'b0;
                beats     = 0;
            end else if (beats < 4) begin
                v = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
                mem_valid = v;
                if (v) begin
                    mem_data = mem_word(mem_addr + 32'(beats * 4));
                    beats++;
                end
            end else begin
                mem_valid = 1'b0;
            end
        end
    end

    // Monitor: every enable pulse and every refill start is matched against the queues.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ea;
        if (!rst) begin
            if (icache_instq_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_enable cyc=%0d inst=%h required=no pulse", cyc, icache_instq_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (icache_instq_inst !== e.inst || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL inst_resp got inst=%h cyc=%0d required inst=%h cyc=%0d",
                                 icache_instq_inst, cyc, e.inst, e.cyc);
                    end
                end
            end
            if (mem_req && !prev_req) begin
                checks++;
                if (maddr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_refill mem_addr=%h required=no refill", mem_addr);
                end else begin
                    ea = maddr_q.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL refill_addr got %h required %h", mem_addr, ea);
                    end
                end
            end
        end
        prev_req = mem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    task automatic issue_hit(input logic [31:0] a, input logic [31:0] want);
        exp_t e;
        e.inst = want;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        pc_icache_ce = 1'b1;
        icache_addr  = a;
        step();
    endtask

    // Holds ce with a junk address through the refill; the cache must ignore it.
    task automatic issue_miss(input logic [31:0] a, input logic [31:0] want,
                              input logic [31:0] base, input int lat);
        exp_t e;
        e.inst = want;
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
        maddr_q.push_back(base);
        pc_icache_ce = 1'b1;
        icache_addr  = a;
        step();
        for (int i = 0; i < lat - 1; i++) begin
            icache_addr = 32'h0000_0700;
            step();
        end
        pc_icache_ce = 1'b0;
        icache_addr  = '0;
    endtask

    task automatic idle(input int n);
        pc_icache_ce = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #20;
        check("reset_enable", {31'b0, icache_instq_enable}, 32'h0);
        check("reset_inst", icache_instq_inst, 32'h0);
        check("reset_mem_req", {31'b0, mem_req}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Cold miss, then streaming hits from the filled line.
        issue_miss(32'h0000_0008, 32'h33, 32'h0000_0000, 6);
        issue_hit(32'h0000_0000, 32'h11);
        issue_hit(32'h0000_0004, 32'h22);
        issue_hit(32'h0000_0008, 32'h33);
        issue_hit(32'h0000_000C, 32'h44);
        idle(1);
        check("stream_no_refill", {31'b0, mem_req}, 32'h0);

        // Conflict on index 0 with a different tag.
        issue_miss(32'h0000_0400, 32'hCAFE_0400, 32'h0000_0400, 6);
        idle(1);
`ifdef ICACHE_STATS_EN
        check("stat_misses", stat_misses, 32'd2);
        check("stat_hits", stat_hits, 32'd4);
`endif
        issue_miss(32'h0000_0000, 32'h11, 32'h0000_0000, 6);
        idle(1);

        // Gappy memory: 4th beat lands on the 7th refill cycle.
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        issue_miss(32'h0000_0014, 32'hCAFE_0014, 32'h0000_0010, 9);
        issue_hit(32'h0000_0010, 32'hCAFE_0010);
        issue_hit(32'h0000_0018, 32'hCAFE_0018);
        issue_hit(32'h0000_001C, 32'hCAFE_001C);
        idle(1);

        // Top of the address space maps to the last line.
        issue_miss(32'hFFFF_FFFC, 32'h3501_FFFC, 32'hFFFF_FFF0, 6);
        issue_hit(32'hFFFF_FFF4, 32'h3501_FFF4);
        idle(1);

        // Reset after two beats abandons the refill.
        maddr_q.push_back(32'h0000_0100);
        pc_icache_ce = 1'b1;
        icache_addr  = 32'h0000_0100;
        step();
        pc_icache_ce = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mid_enable", {31'b0, icache_instq_enable}, 32'h0);
        step();
        step();
        rst = 1'b0;
        step();
        issue_miss(32'h0000_0100, 32'hCAFE_0100, 32'h0000_0100, 6);
        issue_miss(32'h0000_0000, 32'h11, 32'h0000_0000, 6);
        idle(3);

        check("pending_responses", 32'(exp_q.size()), 32'd0);
        check("pending_refills", 32'(maddr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required=finish before limit", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped instruction cache that answers the CPU core's instruction-fetch port (pc_icache_ce / icache_addr in, icache_instq_enable / icache_instq_inst out).
- Hits return in 1 cycle.
- Misses refill a 4-word line from a word-wide backing memory through a request/valid handshake, then return the requested word.
- Sits between the CPU top and the instruction memory.

Parameters:
- ADDR_WIDTH, 32, byte address width of the fetch and memory ports.
- INST_WIDTH, 32, instruction/data word width.
- INDEX_BITS, 6, log2 of the number of lines (64 lines).
- Line size is fixed at 4 words (offset = addr[3:2]). Tag = addr[ADDR_WIDTH-1:4+INDEX_BITS]. addr[1:0] is ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_icache_ce  in  1  fetch request.
- icache_addr  in  ADDR_WIDTH  fetch byte address.
- icache_instq_enable  out  1  one-cycle pulse: instruction valid.
- icache_instq_inst  out  INST_WIDTH  fetched instruction.
- mem_req  out  1  refill request, held until the last beat.
- mem_addr  out  ADDR_WIDTH  line base address (addr[3:0]=0).
- mem_valid  in  1  beat valid; one word per cycle when high.
- mem_data  in  INST_WIDTH  refill beat data, in increasing word order.

Behaviour:
- Reset (async, while rst=1):
  - All valid bits cleared.
  - FSM goes to IDLE.
  - icache_instq_enable=0, icache_instq_inst=0, mem_req=0, mem_addr=0.
  - Tag and data arrays are not cleared.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - A request is accepted only when pc_icache_ce=1; the address is registered as req_addr.
  - Hit (valid[index] && tag match): next cycle icache_instq_enable=1 with data[index][offset]; stay in IDLE. Back-to-back hits give 1 instruction per cycle.
  - Miss: next cycle mem_req=1, mem_addr={tag,index,4'b0}, beat counter=0, go to REFILL. icache_instq_enable stays 0.
- REFILL:
  - Each cycle with mem_valid=1: write mem_data to data[index][beat] and increment beat.
  - On beat 3: write the tag, set valid, drop mem_req the next cycle, go to RESPOND.
  - mem_valid may have gaps of any length; the beat counter holds during them.
  - mem_valid while in IDLE or RESPOND is ignored.
- RESPOND:
  - Outputs icache_instq_enable=1 with the requested word (the offset can be any of 0..3), then returns to IDLE.
  - Miss latency = 4 beats + 2 cycles when mem_valid is continuous.
- pc_icache_ce while in REFILL or RESPOND is ignored. The requester keeps ce/addr asserted and re-issues the request; after icache_instq_enable it must present the next address or drop ce, because every ce=1 cycle in IDLE is a new request.
- icache_instq_enable is a single-cycle pulse. icache_instq_inst holds its last value when enable=0.
- Refill beats write into the line before valid is set. A line is never reported valid with partial data.
- Reset asserted mid-refill: mem_req drops immediately, the partial line stays invalid, and the refill is abandoned. Memory must tolerate the abandoned burst.
- Address wrap: an address near 2^ADDR_WIDTH-1 maps normally. There is no cross-line access because fetch is word-aligned.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds two output ports, stat_hits and stat_misses, each 32 bits.
  - stat_hits increments on each IDLE hit; stat_misses increments on each miss accept.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Cold miss:
  - Stimulus: after rst, ce=1, addr=0x0000_0008; memory returns 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Response: mem_req=1 with mem_addr=0x0000_0000; one enable pulse with inst=0x33 exactly 6 cycles after accept.
- Hit streaming:
  - Stimulus: after the above, addr 0x0,0x4,0x8,0xC on consecutive cycles.
  - Response: 4 consecutive enable pulses, inst 0x11,0x22,0x33,0x44, mem_req stays 0.
- Conflict miss:
  - Stimulus: addr 0x0000_0400 (same index 0, different tag, INDEX_BITS=6).
  - Response: refill issued to 0x0000_0400. A subsequent addr 0x0 misses again.
- Stalled memory:
  - Stimulus: mem_valid toggles 1,0,0,1,1,0,1.
  - Response: exactly 4 words captured in order; enable fires 2 cycles after the 4th beat; ce during refill is ignored.
- Reset mid-refill:
  - Stimulus: rst pulsed after 2 beats.
  - Response: mem_req=0 and enable=0 at once; re-requesting the same addr misses and refills fully.
- With ICACHE_STATS_EN:
  - Stimulus: run the first three scenarios.
  - Response: stat_misses=2, stat_hits=4.
